fetch_ctrl: RTL

Instruction-fetch controller that owns the 512×32 instruction memory port and sequences it for the LEGv8 datapath. It holds the 64-bit PC, advances it by 4 per cycle, and applies stalls and branch redirects. It stops on an all-zero instruction word. It arbitrates the single memory port between CPU fetch and a program-download loader. It sits between the instruction memory (combinational read, synchronous write) and the decode stage.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_ctrl_pc_next.sv | 25 ++
 rtl/fetch_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// default widths and the word that stops fetch.
package fetch_pkg;

    localparam int PC_W   = 64;
    localparam int ADDR_W = 9;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC selection: branch redirect beats stall, stall beats
// the sequential +4 step. Branch targets are forced to word alignment.
module pc_next #(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic [PC_W-1:0] pc_next_o
);

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    always_comb begin
        pc_next_o = pc_i + PC_STEP;
        if (br_taken_i) begin
            pc_next_o = br_target_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the single instruction-memory port,
// sequencing PC fetch in RUN and handing the port to the loader in LOAD.
module fetch_ctrl #(
    parameter int              PC_W     = fetch_pkg::PC_W,
    parameter int              ADDR_W   = fetch_pkg::ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic [31:0]       im_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_we,
    output logic [31:0]       im_wdata,
    output logic [PC_W-1:0]   pc,
    output logic [31:0]       instr,
    output logic              if_valid,
    output logic              halted
);

    import fetch_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_seq;
    logic [ADDR_W-1:0] pc_word;

    // Only the low word-address bits reach memory, so fetch wraps every 2 KiB
    // while the architectural PC keeps counting.
    assign pc_word = pc_q[ADDR_W+1:2];

    pc_next #(
        .PC_W(PC_W)
    ) u_pc_next (
        .pc_i       (pc_q),
        .stall_i    (stall),
        .br_taken_i (br_taken),
        .br_target_i(br_target),
        .pc_next_o  (pc_seq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        im_addr    = '0;
        im_we      = 1'b0;
        im_wdata   = '0;
        load_ready = 1'b0;
        if_valid   = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = load_req ? ST_LOAD : ST_RUN;
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                im_addr    = load_addr;
                im_wdata   = load_data;
                im_we      = load_valid;
                if (!load_req) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                im_addr = pc_word;
                // A pending loader request freezes the PC and withdraws the fetch.
                if (load_req) begin
                    state_d = ST_LOAD;
                end else begin
                    if_valid = 1'b1;
                    pc_d     = pc_seq;
                    if (im_rdata == HALT_WORD && !br_taken) begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                end
            end
            ST_HALT: begin
                halted  = 1'b1;
                im_addr = pc_word;
                if (load_req) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc    = pc_q;
    assign instr = im_rdata;

endmodule
